// File: rtl/dsec_pkg.sv
// Shared constants for the DSEC receive path: key FSM encodings, error code,
// and the DES tables plus a single-DES block function used by the 3DES core.
package dsec_pkg;

    localparam int DES_W = 64;

    localparam logic [1:0] ST_NOKEY = 2'd0;
    localparam logic [1:0] ST_KEY2  = 2'd1;
    localparam logic [1:0] ST_KEY3  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [DES_W-1:0] ERR_NO_KEY = 64'hDEAD_0000_0000_0001;

    // DES tables use the standard 1-based, MSB-first bit numbering.
    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                                 8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                                16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                                24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                  10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                  14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                  23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s_out;
        logic [31:0] f;
        logic [5:0]  six;
        for (int j = 0; j < 48; j++) x[47-j] = r[5'(32 - E_T[j])];
        x = x ^ k;
        for (int s = 0; s < 8; s++) begin
            six = x[47-6*s -: 6];
            s_out[31-4*s -: 4] = 4'(SBOX[s][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) f[31-i] = s_out[5'(32 - P_T[i])];
        return f;
    endfunction

    // Single DES; decryption is the same network with the subkeys applied in reverse.
    function automatic logic [DES_W-1:0] des_crypt(input logic [DES_W-1:0] blk,
                                                   input logic [DES_W-1:0] key,
                                                   input logic             decrypt);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sub [16];
        logic [63:0] perm, pre, res;
        logic [31:0] l, r, t;
        for (int i = 0; i < 56; i++) cd[55-i] = key[6'(64 - PC1_T[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            if (n == 0 || n == 1 || n == 8 || n == 15) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end else begin
                c = {c[25:0], c[27:26]};
                d = {d[25:0], d[27:26]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) sub[n][47-j] = cd[6'(56 - PC2_T[j])];
        end
        for (int i = 0; i < 64; i++) perm[63-i] = blk[6'(64 - IP_T[i])];
        l = perm[63:32];
        r = perm[31:0];
        for (int n = 0; n < 16; n++) begin
            t = l ^ des_f(r, decrypt ? sub[15-n] : sub[n]);
            l = r;
            r = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[6'(64 - FP_T[i])];
        return res;
    endfunction

endpackage

// File: rtl/TripleDES_Decryption.sv
// Combinational 3DES EDE inverse: P = D_k1(E_k2(D_k3(C))).
module TripleDES_Decryption
    import dsec_pkg::*;
(
    input  logic [DES_W-1:0] data_in,
    input  logic [DES_W-1:0] key_1,
    input  logic [DES_W-1:0] key_2,
    input  logic [DES_W-1:0] key_3,
    output logic [DES_W-1:0] data_out
);

    logic [DES_W-1:0] w_dec_3;
    logic [DES_W-1:0] w_enc_2;

    assign w_dec_3  = des_crypt(data_in, key_3, 1'b1);
    assign w_enc_2  = des_crypt(w_dec_3, key_2, 1'b0);
    assign data_out = des_crypt(w_enc_2, key_1, 1'b1);

endmodule

// File: rtl/dsec_rx.sv
// DSEC receiver: key-load FSM, one-word ciphertext stage feeding a 3DES decryptor,
// and a plaintext FIFO drained over the out_valid/out_rcvd handshake.
module dsec_rx
    import dsec_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DES_W-1:0] data_in,
    input  logic             key_config,
    input  logic             in_valid,
    output logic             rdy,
    output logic [DES_W-1:0] data_out,
    output logic             out_valid,
    input  logic             out_rcvd,
    output logic             error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]       r_state;
    logic [DES_W-1:0] r_key_1, r_key_2, r_key_3;
    logic             r_error;
    logic             r_stage_valid;
    logic [DES_W-1:0] r_stage_data;
    logic [DES_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_accept, w_key_beat, w_data_beat, w_stage_load;
    logic             w_push, w_pop;
    logic [DES_W-1:0] w_plain;

    // Holding key_config off while a word is staged keeps its keys stable until it is decrypted.
    assign rdy = rst_n
               & ((r_count + CNT_W'(r_stage_valid)) < CNT_W'(FIFO_DEPTH))
               & ~(key_config & r_stage_valid);

    assign w_accept     = in_valid & rdy;
    assign w_key_beat   = w_accept & key_config;
    assign w_data_beat  = w_accept & ~key_config;
    assign w_stage_load = w_data_beat & (r_state == ST_RUN);
    assign w_push       = r_stage_valid;
    assign w_pop        = out_valid & out_rcvd;

    assign out_valid = (r_count != '0);
    assign data_out  = r_error ? ERR_NO_KEY : r_fifo[r_rd_ptr];
    assign error     = r_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_NOKEY;
            r_key_1 <= '0;
            r_key_2 <= '0;
            r_key_3 <= '0;
            r_error <= 1'b0;
        end else if (w_key_beat) begin
            r_state <= ST_KEY2;
            r_key_1 <= data_in;
            r_error <= 1'b0;
        end else if (w_data_beat) begin
            case (r_state)
                ST_NOKEY: r_error <= 1'b1;
                ST_KEY2: begin
                    r_key_2 <= data_in;
                    r_state <= ST_KEY3;
                end
                ST_KEY3: begin
                    r_key_3 <= data_in;
                    r_state <= ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
        end else begin
            r_stage_valid <= w_stage_load;
            if (w_stage_load) r_stage_data <= data_in;
        end
    end

    TripleDES_Decryption u_tdes (
        .data_in  (r_stage_data),
        .key_1    (r_key_1),
        .key_2    (r_key_2),
        .key_3    (r_key_3),
        .data_out (w_plain)
    );

    // NOTE: the FIFO storage is reset too, because data_out must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_plain;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsec_rx.sv
// Directed bench for dsec_rx using published DES known-answer vectors (k1=k2=k3 reduces 3DES to DES).
module tb_dsec_rx;

    localparam logic [63:0] K_STD  = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] C_STD  = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] P_STD  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] K_ZERO = 64'h0101_0101_0101_0101;
    localparam logic [63:0] C_ZERO = 64'h8CA6_4DE9_C1B1_23A7;
    localparam logic [63:0] K_ONES = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] C_ONES = 64'h7359_B216_3E4E_DC58;
    localparam logic [63:0] ERR    = 64'hDEAD_0000_0000_0001;
    // Ciphertexts of 64'h8000.. >> i under the all-zero key.
    localparam logic [63:0] VP_C [8] = '{64'h95F8A5E5DD31D900, 64'hDD7F121CA5015619,
                                         64'h2E8653104F3834EA, 64'h4BD388FF6CD81D4F,
                                         64'h20B9E767B2FB1456, 64'h55579380D77138EF,
                                         64'h6CC5DEFAAF04512F, 64'h0D9F279BA5D87260};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data_in = '0;
    logic        key_config = 1'b0;
    logic        in_valid = 1'b0;
    logic        rdy;
    logic [63:0] data_out;
    logic        out_valid;
    logic        out_rcvd = 1'b0;
    logic        error;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dsec_rx #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .key_config (key_config),
        .in_valid   (in_valid),
        .rdy        (rdy),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_rcvd   (out_rcvd),
        .error      (error)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; key_config = 1'b0; rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Presents one beat and holds it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [63:0] d, input logic kc);
        int budget;
        budget = 20;
        @(negedge clk);
        data_in = d; key_config = kc; in_valid = 1'b1;
        #1;
        while (rdy !== 1'b1 && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        if (budget == 0) begin
            total++;
            $display("FAIL send_timeout: rdy=%b, required 1", rdy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; key_config = 1'b0;
    endtask

    task automatic load_keys(input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3);
        send(k1, 1'b1);
        send(k2, 1'b0);
        send(k3, 1'b0);
    endtask

    task automatic wait_valid();
        int budget;
        budget = 10;
        while (out_valid !== 1'b1 && budget > 0) begin
            @(posedge clk); #1; budget--;
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b, required 0", rdy); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else passed++;
        total++; if (error !== 1'b0) $display("FAIL reset_error: got %b, required 0", error); else passed++;
        total++; if (data_out !== 64'h0) $display("FAIL reset_data_out: got %h, required 0", data_out); else passed++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_decrypt();
        out_rcvd = 1'b1;
        load_keys(K_STD, K_STD, K_STD);
        @(negedge clk);
        data_in = C_STD; in_valid = 1'b1;
        #1;
        total++; if (rdy !== 1'b1) $display("FAIL dec_rdy: got %b, required 1", rdy); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL dec_latency_stage: out_valid=%b, required 0", out_valid); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) $display("FAIL dec_latency_out: out_valid=%b, required 1", out_valid); else passed++;
        total++; if (data_out !== P_STD) $display("FAIL dec_std: got %h, required %h", data_out, P_STD); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL dec_popped: out_valid=%b, required 0", out_valid); else passed++;

        load_keys(K_ONES, K_ONES, K_ONES);
        send(C_ONES, 1'b0);
        wait_valid();
        total++; if (out_valid !== 1'b1) $display("FAIL dec_ones_valid: got %b, required 1", out_valid); else passed++;
        total++; if (data_out !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL dec_ones: got %h, required ffffffffffffffff", data_out); else passed++;
    endtask

    task automatic test_no_key();
        do_reset();
        send(C_STD, 1'b0);
        total++; if (error !== 1'b1) $display("FAIL nokey_error: got %b, required 1", error); else passed++;
        total++; if (data_out !== ERR) $display("FAIL nokey_data_out: got %h, required %h", data_out, ERR); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL nokey_out_valid: got %b, required 0", out_valid); else passed++;
        send(K_ZERO, 1'b1);
        total++; if (error !== 1'b0) $display("FAIL nokey_clear: got %b, required 0", error); else passed++;
        send(K_ZERO, 1'b0);
        send(K_ZERO, 1'b0);
    endtask

    task automatic test_back_to_back();
        int sent, got;
        logic accept_now;
        logic [63:0] exp;
        sent = 0; got = 0;
        out_rcvd = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            data_in = VP_C[sent]; key_config = 1'b0; in_valid = 1'b1;
            #1;
            if (rdy === 1'b1) sent++;
            @(posedge clk);
        end
        #1;
        total++; if (sent != 4) $display("FAIL bp_accepts: got %0d, required 4", sent); else passed++;
        total++; if (rdy !== 1'b0) $display("FAIL bp_rdy_low: got %b, required 0", rdy); else passed++;
        total++; if (data_out !== 64'h8000_0000_0000_0000)
            $display("FAIL bp_head: got %h, required 8000000000000000", data_out); else passed++;

        out_rcvd = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            if (sent < 8) begin data_in = VP_C[sent]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            accept_now = in_valid & rdy;
            if (out_valid === 1'b1) begin
                exp = 64'h8000_0000_0000_0000 >> got;
                total++; if (data_out !== exp)
                    $display("FAIL bp_word%0d: got %h, required %h", got, data_out, exp); else passed++;
                got++;
            end
            @(posedge clk);
            if (accept_now) sent++;
        end
        in_valid = 1'b0;
        total++; if (got != 8) $display("FAIL bp_delivered: got %0d, required 8", got); else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: out_valid=%b, required 0", out_valid); else passed++;
    endtask

    task automatic test_key_during_stage();
        out_rcvd = 1'b1;
        @(negedge clk);
        data_in = C_ZERO; key_config = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        data_in = K_STD; key_config = 1'b1;
        #1;
        total++; if (rdy !== 1'b0) $display("FAIL kstage_rdy_low: got %b, required 0", rdy); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) $display("FAIL kstage_valid: got %b, required 1", out_valid); else passed++;
        total++; if (data_out !== 64'h0) $display("FAIL kstage_old_keys: got %h, required 0", data_out); else passed++;
        total++; if (rdy !== 1'b1) $display("FAIL kstage_rdy_high: got %b, required 1", rdy); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0; key_config = 1'b0;
        send(K_STD, 1'b0);
        send(K_STD, 1'b0);
        send(C_STD, 1'b0);
        wait_valid();
        total++; if (data_out !== P_STD) $display("FAIL kstage_new_keys: got %h, required %h", data_out, P_STD); else passed++;
    endtask

    task automatic test_key_restart();
        out_rcvd = 1'b1;
        send(K_ZERO, 1'b1);
        send(K_ZERO, 1'b0);
        send(~K_STD, 1'b1);
        send(~K_STD, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL restart_no_data: out_valid=%b, required 0", out_valid); else passed++;
        send(~K_STD, 1'b0);
        send(~C_STD, 1'b0);
        wait_valid();
        total++; if (out_valid !== 1'b1) $display("FAIL restart_valid: got %b, required 1", out_valid); else passed++;
        total++; if (data_out !== ~P_STD) $display("FAIL restart_data: got %h, required %h", data_out, ~P_STD); else passed++;
    endtask

    task automatic test_reset_midstream();
        out_rcvd = 1'b0;
        send(C_STD, 1'b0);
        send(C_STD, 1'b0);
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) $display("FAIL mid_prefill: out_valid=%b, required 1", out_valid); else passed++;
        #3 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b, required 0", out_valid); else passed++;
        total++; if (error !== 1'b0) $display("FAIL mid_error: got %b, required 0", error); else passed++;
        total++; if (data_out !== 64'h0) $display("FAIL mid_data_out: got %h, required 0", data_out); else passed++;
        total++; if (rdy !== 1'b0) $display("FAIL mid_rdy: got %b, required 0", rdy); else passed++;
        @(negedge clk); rst_n = 1'b1;
        send(C_STD, 1'b0);
        total++; if (error !== 1'b1) $display("FAIL mid_post_error: got %b, required 1", error); else passed++;
        total++; if (data_out !== ERR) $display("FAIL mid_post_data: got %h, required %h", data_out, ERR); else passed++;
    endtask

    initial begin
        test_reset();
        test_decrypt();
        test_no_key();
        test_back_to_back();
        test_key_during_stage();
        test_key_restart();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
